display_timings: RTL and testbench

- Pixel-clock timing generator for the display controller.
- Produces the pixel coordinate pair, sync pulses, data-enable and frame/line markers for one video mode.
- Sits directly upstream of the test-card pattern stages: o_x/o_y (16-bit unsigned) feed their coordinate inputs; o_hs/o_vs/o_de go to the output encoder alongside the returned colour.

---
 rtl/display_pkg.sv | 37 +++
 rtl/display_timings_if.sv | 33 +++
 rtl/display_timing_axis.sv | 76 +++++++
 rtl/display_timings.sv | 101 ++++++++++
 tb/tb_display_timings.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared constants for the display timing generator: the
//                coordinate width and per-axis timing sets for the supported
//                video modes.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Width of every coordinate counter and coordinate output
    localparam int c_COORD_W = 16;

    // One axis of a video mode: active, front porch, sync, back porch, polarity
    typedef struct packed {
        int res;
        int fp;
        int sync;
        int bp;
        bit pol;
    } axis_timing_t;

    // 640x480@60, negative syncs
    localparam axis_timing_t c_VGA_H = '{res: 640,  fp: 16,  sync: 96, bp: 48,  pol: 1'b0};
    localparam axis_timing_t c_VGA_V = '{res: 480,  fp: 10,  sync: 2,  bp: 33,  pol: 1'b0};

    // 1280x720@60, positive syncs
    localparam axis_timing_t c_HD_H  = '{res: 1280, fp: 110, sync: 40, bp: 220, pol: 1'b1};
    localparam axis_timing_t c_HD_V  = '{res: 720,  fp: 5,   sync: 5,  bp: 20,  pol: 1'b1};

    // Total pixels (or lines) in one period of an axis
    function automatic int axis_total(input axis_timing_t t);
        return t.res + t.fp + t.sync + t.bp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_timings_if.sv
`default_nettype none
// ============================================================================
//  Module      : display_timings_if
//  Description : Strobe input plus coordinate/sync/marker outputs of the
//                display timing generator. The master is the generator, the
//                slave is whoever drives the strobe and consumes the timing.
//  Revision    : 1.0 - initial release
// ============================================================================
interface display_timings_if;
    import display_pkg::*;

    logic                 i_stb;
    logic [c_COORD_W-1:0] o_x;
    logic [c_COORD_W-1:0] o_y;
    logic                 o_hs;
    logic                 o_vs;
    logic                 o_de;
    logic                 o_frame;
    logic                 o_line;
    logic                 o_animate;

    modport master (
        input  i_stb,
        output o_x, o_y, o_hs, o_vs, o_de, o_frame, o_line, o_animate
    );

    modport slave (
        output i_stb,
        input  o_x, o_y, o_hs, o_vs, o_de, o_frame, o_line, o_animate
    );

endinterface
`default_nettype wire

// File: rtl/display_timing_axis.sv
`default_nettype none
// ============================================================================
//  Module      : display_timing_axis
//  Description : One wrapping coordinate counter with registered sync decode.
//                Exposes the next coordinate and its active flag so the parent
//                can register its own flags in step with the counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_timing_axis
    import display_pkg::*;
#(
    parameter int RES  = 640,
    parameter int FP   = 16,
    parameter int SYNC = 96,
    parameter int BP   = 48,
    parameter bit POL  = 1'b0
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_en,
    output logic [c_COORD_W-1:0]      o_pos,
    output logic                      o_sync,
    output logic [c_COORD_W-1:0]      o_pos_d,
    output logic                      o_active_d,
    output logic                      o_wrap
);

    localparam int                   c_TOTAL    = RES + FP + SYNC + BP;
    localparam logic [c_COORD_W-1:0] c_LAST     = c_COORD_W'(c_TOTAL - 1);
    localparam logic [c_COORD_W-1:0] c_RES      = c_COORD_W'(RES);
    localparam logic [c_COORD_W-1:0] c_SYNC_BEG = c_COORD_W'(RES + FP);
    localparam logic [c_COORD_W-1:0] c_SYNC_END = c_COORD_W'(RES + FP + SYNC);

    // A 16-bit counter reaches 65535 at most, and empty porches or syncs
    // would collapse the decode ranges.
    if (c_TOTAL > 65536 || FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_timing
        $error("display_timing_axis: total exceeds 65536 or a porch/sync width is zero");
    end

    logic [c_COORD_W-1:0] r_pos_q;
    logic                 r_sync_q;
    logic [c_COORD_W-1:0] w_pos_d;
    logic                 w_sync_d;

    assign o_wrap = i_en && (r_pos_q == c_LAST);

    // Next coordinate: wrap at the last position, otherwise step when enabled
    always_comb begin
        w_pos_d = r_pos_q;
        if (o_wrap) begin
            w_pos_d = '0;
        end else if (i_en) begin
            w_pos_d = r_pos_q + 1'b1;
        end
    end

    assign w_sync_d   = (w_pos_d >= c_SYNC_BEG && w_pos_d < c_SYNC_END) ? POL : ~POL;
    assign o_active_d = (w_pos_d < c_RES);

    // Counter and sync registered together; reset parks on the last blanking slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos_q  <= c_LAST;
            r_sync_q <= ~POL;
        end else begin
            r_pos_q  <= w_pos_d;
            r_sync_q <= w_sync_d;
        end
    end

    assign o_pos   = r_pos_q;
    assign o_sync  = r_sync_q;
    assign o_pos_d = w_pos_d;

endmodule
`default_nettype wire

// File: rtl/display_timings.sv
`default_nettype none
// ============================================================================
//  Module      : display_timings
//  Description : Pixel-strobe timing generator. Two chained axis counters give
//                the coordinate pair and syncs; data-enable and frame/line/
//                animate markers are derived from the next coordinate and
//                registered with it so every output describes the same pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_timings
    import display_pkg::*;
#(
    parameter int H_RES  = c_VGA_H.res,
    parameter int H_FP   = c_VGA_H.fp,
    parameter int H_SYNC = c_VGA_H.sync,
    parameter int H_BP   = c_VGA_H.bp,
    parameter bit H_POL  = c_VGA_H.pol,
    parameter int V_RES  = c_VGA_V.res,
    parameter int V_FP   = c_VGA_V.fp,
    parameter int V_SYNC = c_VGA_V.sync,
    parameter int V_BP   = c_VGA_V.bp,
    parameter bit V_POL  = c_VGA_V.pol
) (
    input  wire logic          i_pix_clk,
    input  wire logic          i_rst,
    display_timings_if.master  bus
);

    localparam logic [c_COORD_W-1:0] c_ANIM_X = c_COORD_W'(H_RES);
    localparam logic [c_COORD_W-1:0] c_ANIM_Y = c_COORD_W'(V_RES - 1);

    logic [c_COORD_W-1:0] w_x_d;
    logic [c_COORD_W-1:0] w_y_d;
    logic                 w_h_act_d;
    logic                 w_v_act_d;
    logic                 w_h_wrap;
    logic                 w_v_wrap;

    logic r_de_q;
    logic r_frame_q;
    logic r_line_q;
    logic r_animate_q;

    display_timing_axis #(
        .RES  (H_RES),
        .FP   (H_FP),
        .SYNC (H_SYNC),
        .BP   (H_BP),
        .POL  (H_POL)
    ) u_h_axis (
        .clk        (i_pix_clk),
        .rst        (i_rst),
        .i_en       (bus.i_stb),
        .o_pos      (bus.o_x),
        .o_sync     (bus.o_hs),
        .o_pos_d    (w_x_d),
        .o_active_d (w_h_act_d),
        .o_wrap     (w_h_wrap)
    );

    // The vertical counter steps only on a strobed horizontal wrap
    display_timing_axis #(
        .RES  (V_RES),
        .FP   (V_FP),
        .SYNC (V_SYNC),
        .BP   (V_BP),
        .POL  (V_POL)
    ) u_v_axis (
        .clk        (i_pix_clk),
        .rst        (i_rst),
        .i_en       (w_h_wrap),
        .o_pos      (bus.o_y),
        .o_sync     (bus.o_vs),
        .o_pos_d    (w_y_d),
        .o_active_d (w_v_act_d),
        .o_wrap     (w_v_wrap)
    );

    // Flags follow the next coordinate and hold between strobes; a wrap of
    // both axes means the next pixel is (0,0), a horizontal wrap means x==0
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            r_de_q      <= 1'b0;
            r_frame_q   <= 1'b0;
            r_line_q    <= 1'b0;
            r_animate_q <= 1'b0;
        end else if (bus.i_stb) begin
            r_de_q      <= w_h_act_d && w_v_act_d;
            r_frame_q   <= w_v_wrap;
            r_line_q    <= w_h_wrap;
            r_animate_q <= (w_x_d == c_ANIM_X) && (w_y_d == c_ANIM_Y);
        end
    end

    assign bus.o_de      = r_de_q;
    assign bus.o_frame   = r_frame_q;
    assign bus.o_line    = r_line_q;
    assign bus.o_animate = r_animate_q;

endmodule
`default_nettype wire

// File: tb/tb_display_timings.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_timings
//  Description : Directed self-checking bench for display_timings. Runs a
//                640x480 instance, a 1280x720 instance and a tiny-mode
//                instance (15x8 total) that makes whole frames affordable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_timings;
    import display_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    display_timings_if bus_vga ();
    display_timings_if bus_hd  ();
    display_timings_if bus_sm  ();

    display_timings u_vga (
        .i_pix_clk (clk),
        .i_rst     (rst),
        .bus       (bus_vga)
    );

    display_timings #(
        .H_RES (c_HD_H.res), .H_FP (c_HD_H.fp), .H_SYNC (c_HD_H.sync), .H_BP (c_HD_H.bp), .H_POL (c_HD_H.pol),
        .V_RES (c_HD_V.res), .V_FP (c_HD_V.fp), .V_SYNC (c_HD_V.sync), .V_BP (c_HD_V.bp), .V_POL (c_HD_V.pol)
    ) u_hd (
        .i_pix_clk (clk),
        .i_rst     (rst),
        .bus       (bus_hd)
    );

    // Tiny mode: H 8/2/3/2 (total 15, hsync 10..12), V 4/1/2/1 (total 8, vsync 5..6)
    display_timings #(
        .H_RES (8), .H_FP (2), .H_SYNC (3), .H_BP (2), .H_POL (1'b0),
        .V_RES (4), .V_FP (1), .V_SYNC (2), .V_BP (1), .V_POL (1'b0)
    ) u_sm (
        .i_pix_clk (clk),
        .i_rst     (rst),
        .bus       (bus_sm)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [39:0] obs;
        logic [39:0] exp;
        rst = 1'b1;
        bus_vga.i_stb = 1'b1;
        bus_hd.i_stb  = 1'b1;
        bus_sm.i_stb  = 1'b1;
        repeat (3) tick();
        obs = {bus_vga.o_x, bus_vga.o_y, bus_vga.o_hs, bus_vga.o_vs, bus_vga.o_de,
               bus_vga.o_frame, bus_vga.o_line, bus_vga.o_animate};
        exp = {16'd799, 16'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) $display("FAIL vga_reset_state: got %h expected %h", obs, exp);
        else n_pass++;
        obs = {bus_hd.o_x, bus_hd.o_y, bus_hd.o_hs, bus_hd.o_vs, bus_hd.o_de,
               bus_hd.o_frame, bus_hd.o_line, bus_hd.o_animate};
        exp = {16'd1649, 16'd749, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) $display("FAIL hd_reset_state: got %h expected %h", obs, exp);
        else n_pass++;
        rst = 1'b0;
        tick();
        obs = {bus_vga.o_x, bus_vga.o_y, bus_vga.o_hs, bus_vga.o_vs, bus_vga.o_de,
               bus_vga.o_frame, bus_vga.o_line, bus_vga.o_animate};
        exp = {16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp) $display("FAIL vga_first_pixel: got %h expected %h", obs, exp);
        else n_pass++;
    endtask

    task automatic test_line;
        int bad = 0;
        int de_cnt = 0;
        int hs_low = 0;
        for (int i = 0; i < 800; i++) begin
            if (bus_vga.o_x !== 16'(i) || bus_vga.o_y !== 16'd0 ||
                bus_vga.o_de !== (i < 640) || bus_vga.o_hs !== !(i >= 656 && i <= 751) ||
                bus_vga.o_line !== (i == 0) || bus_vga.o_frame !== (i == 0)) bad++;
            if (bus_vga.o_de === 1'b1) de_cnt++;
            if (bus_vga.o_hs === 1'b0) hs_low++;
            tick();
        end
        n_checks++;
        if (bad != 0) $display("FAIL vga_line_sequence: got %0d bad pixels expected 0", bad);
        else n_pass++;
        n_checks++;
        if (de_cnt != 640) $display("FAIL vga_de_width: got %0d expected 640", de_cnt);
        else n_pass++;
        n_checks++;
        if (hs_low != 96) $display("FAIL vga_hs_width: got %0d expected 96", hs_low);
        else n_pass++;
        n_checks++;
        if ({bus_vga.o_x, bus_vga.o_y, bus_vga.o_line} !== {16'd0, 16'd1, 1'b1})
            $display("FAIL vga_line_wrap: got x=%0d y=%0d line=%b expected x=0 y=1 line=1",
                     bus_vga.o_x, bus_vga.o_y, bus_vga.o_line);
        else n_pass++;
    endtask

    task automatic test_frame;
        int bad = 0;
        int vs_low = 0;
        int anim = 0;
        int de_cnt = 0;
        int ex, ey;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 120; i++) begin
            ex = i % 15;
            ey = i / 15;
            if (bus_sm.o_x !== 16'(ex) || bus_sm.o_y !== 16'(ey) ||
                bus_sm.o_de !== (ex < 8 && ey < 4) ||
                bus_sm.o_hs !== !(ex >= 10 && ex <= 12) ||
                bus_sm.o_vs !== !(ey >= 5 && ey <= 6) ||
                bus_sm.o_frame !== (i == 0) || bus_sm.o_line !== (ex == 0) ||
                bus_sm.o_animate !== (ex == 8 && ey == 3)) bad++;
            if (bus_sm.o_vs === 1'b0) vs_low++;
            if (bus_sm.o_animate === 1'b1) anim++;
            if (bus_sm.o_de === 1'b1) de_cnt++;
            tick();
        end
        n_checks++;
        if (bad != 0) $display("FAIL sm_frame_sequence: got %0d bad pixels expected 0", bad);
        else n_pass++;
        n_checks++;
        if (vs_low != 30) $display("FAIL sm_vs_width: got %0d expected 30", vs_low);
        else n_pass++;
        n_checks++;
        if (anim != 1) $display("FAIL sm_animate_count: got %0d expected 1", anim);
        else n_pass++;
        n_checks++;
        if (de_cnt != 32) $display("FAIL sm_de_count: got %0d expected 32", de_cnt);
        else n_pass++;
        n_checks++;
        if ({bus_sm.o_x, bus_sm.o_y, bus_sm.o_frame} !== {16'd0, 16'd0, 1'b1})
            $display("FAIL sm_frame_period: got x=%0d y=%0d frame=%b expected x=0 y=0 frame=1",
                     bus_sm.o_x, bus_sm.o_y, bus_sm.o_frame);
        else n_pass++;
    endtask

    task automatic test_strobe;
        int s = 0;
        int bad = 0;
        int fr_cnt = 0;
        int rise0 = -1;
        int rise1 = -1;
        logic prev_fr = 1'b0;
        logic stb;
        int ex, ey;
        logic efr;
        bus_sm.i_stb = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 500; c++) begin
            stb = (c % 4 == 0);
            bus_sm.i_stb = stb;
            tick();
            if (stb) s++;
            ex  = (s == 0) ? 14 : (s - 1) % 15;
            ey  = (s == 0) ? 7  : ((s - 1) / 15) % 8;
            efr = (s > 0) && ((s - 1) % 120 == 0);
            if (bus_sm.o_x !== 16'(ex) || bus_sm.o_y !== 16'(ey) || bus_sm.o_frame !== efr) bad++;
            if (bus_sm.o_frame === 1'b1) begin
                fr_cnt++;
                if (!prev_fr) begin
                    if (rise0 < 0) rise0 = c;
                    else if (rise1 < 0) rise1 = c;
                end
            end
            prev_fr = (bus_sm.o_frame === 1'b1);
        end
        bus_sm.i_stb = 1'b1;
        n_checks++;
        if (bad != 0) $display("FAIL stb_hold_sequence: got %0d bad cycles expected 0", bad);
        else n_pass++;
        n_checks++;
        if (fr_cnt != 8) $display("FAIL stb_frame_high_clocks: got %0d expected 8", fr_cnt);
        else n_pass++;
        n_checks++;
        if (rise1 - rise0 != 480) $display("FAIL stb_frame_period: got %0d expected 480", rise1 - rise0);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [39:0] obs;
        logic [39:0] exp;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (37) tick();
        n_checks++;
        if ({bus_sm.o_x, bus_sm.o_y} !== {16'd6, 16'd2})
            $display("FAIL mid_position: got x=%0d y=%0d expected x=6 y=2", bus_sm.o_x, bus_sm.o_y);
        else n_pass++;
        rst = 1'b1;
        tick();
        obs = {bus_sm.o_x, bus_sm.o_y, bus_sm.o_hs, bus_sm.o_vs, bus_sm.o_de,
               bus_sm.o_frame, bus_sm.o_line, bus_sm.o_animate};
        exp = {16'd14, 16'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) $display("FAIL mid_reset_state: got %h expected %h", obs, exp);
        else n_pass++;
        rst = 1'b0;
        tick();
        obs = {bus_sm.o_x, bus_sm.o_y, bus_sm.o_hs, bus_sm.o_vs, bus_sm.o_de,
               bus_sm.o_frame, bus_sm.o_line, bus_sm.o_animate};
        exp = {16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp) $display("FAIL mid_restart: got %h expected %h", obs, exp);
        else n_pass++;
    endtask

    task automatic test_hd_line;
        int bad = 0;
        int hs_high = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 1650; i++) begin
            if (bus_hd.o_x !== 16'(i) || bus_hd.o_y !== 16'd0 ||
                bus_hd.o_hs !== (i >= 1390 && i <= 1429) || bus_hd.o_de !== (i < 1280) ||
                bus_hd.o_vs !== 1'b0) bad++;
            if (bus_hd.o_hs === 1'b1) hs_high++;
            tick();
        end
        n_checks++;
        if (bad != 0) $display("FAIL hd_line_sequence: got %0d bad pixels expected 0", bad);
        else n_pass++;
        n_checks++;
        if (hs_high != 40) $display("FAIL hd_hs_width: got %0d expected 40", hs_high);
        else n_pass++;
        n_checks++;
        if ({bus_hd.o_x, bus_hd.o_y, bus_hd.o_line} !== {16'd0, 16'd1, 1'b1})
            $display("FAIL hd_line_wrap: got x=%0d y=%0d line=%b expected x=0 y=1 line=1",
                     bus_hd.o_x, bus_hd.o_y, bus_hd.o_line);
        else n_pass++;
    endtask

    initial begin
        bus_vga.i_stb = 1'b0;
        bus_hd.i_stb  = 1'b0;
        bus_sm.i_stb  = 1'b0;
        test_reset();
        test_line();
        test_frame();
        test_strobe();
        test_reset_mid();
        test_hd_line();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
